// File: rtl/calc_pkg.sv
// Shared calculator definitions: capture FSM state encoding and the number
// of operations the ALU implements (used by the op-code validity check).
package calc_pkg;

   typedef enum logic [1:0] {
      ESPERA_A  = 2'd0,
      ESPERA_B  = 2'd1,
      ESPERA_OP = 2'd2,
      LISTO     = 2'd3
   } estado_t;

   localparam int unsigned NUM_OPS = 10;

endpackage : calc_pkg

// File: rtl/antirrebote.sv
// Button conditioning: 2-flop synchronizer, debounce counter and press
// (rising-edge) detector.
//   clk, rst : clock, asynchronous active-high reset
//   btn_in   : raw asynchronous pushbutton
//   nivel    : debounced button level
//   evento   : one-cycle pulse on each debounced 0->1 transition
module antirrebote #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_in,
   output logic nivel,
   output logic evento
);

   localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             nivel_q, nivel_d;
   logic             evento_q, evento_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next-state: count consecutive disagreeing cycles, toggle once the
   // count has been held at its limit for a further disagreeing cycle.
   always_comb begin
      sync1_d  = btn_in;
      sync2_d  = sync1_q;
      nivel_d  = nivel_q;
      cnt_d    = cnt_q;
      if (sync2_q != nivel_q) begin
         if (cnt_q == CNT_W'(DEBOUNCE_CYCLES)) begin
            nivel_d = ~nivel_q;
            cnt_d   = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_d = '0;
      end
      evento_d = nivel_d & ~nivel_q;
   end

   // Conditioning registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         nivel_q  <= 1'b0;
         evento_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         nivel_q  <= nivel_d;
         evento_q <= evento_d;
         cnt_q    <= cnt_d;
      end
   end

   assign nivel  = nivel_q;
   assign evento = evento_q;

endmodule : antirrebote

// File: rtl/captura_operandos.sv
// Calculator input stage: captures operand A, operand B and the op code from
// the switches, one item per debounced press of the load button, and presents
// them registered with a valid flag.
//   clk, rst    : clock, asynchronous active-high reset
//   btn_cargar  : raw load pushbutton
//   sw_dato     : operand switches (N bits)
//   sw_op       : op-code switches
//   a, b        : captured operands
//   operacion   : captured op code
//   valido      : a/b/operacion form one complete set
//   estado      : current capture state (LEDs)
//   op_invalida : one-cycle pulse when an op code is rejected
// Build option: define OP_VALIDACION_EN to reject op codes >= NUM_OPS.
module captura_operandos
   import calc_pkg::*;
#(
   parameter int unsigned N               = 4,
   parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         btn_cargar,
   input  logic [N-1:0] sw_dato,
   input  logic [3:0]   sw_op,
   output logic [N-1:0] a,
   output logic [N-1:0] b,
   output logic [3:0]   operacion,
   output logic         valido,
   output logic [1:0]   estado,
   output logic         op_invalida
);

   logic evento;
   logic nivel_unused;

   antirrebote #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_antirrebote (
      .clk    (clk),
      .rst    (rst),
      .btn_in (btn_cargar),
      .nivel  (nivel_unused),
      .evento (evento)
   );

   estado_t      estado_q, estado_d;
   logic [N-1:0] a_q, a_d;
   logic [N-1:0] b_q, b_d;
   logic [3:0]   op_q, op_d;
   logic         valido_q, valido_d;
   logic         op_ok;

`ifdef OP_VALIDACION_EN
   logic op_invalida_q, op_invalida_d;
   assign op_ok = (sw_op < 4'(NUM_OPS));
`else
   assign op_ok = 1'b1;
`endif

   // Next-state and capture logic; everything holds without a press
   always_comb begin
      estado_d = estado_q;
      a_d      = a_q;
      b_d      = b_q;
      op_d     = op_q;
      valido_d = valido_q;
`ifdef OP_VALIDACION_EN
      op_invalida_d = 1'b0;
`endif
      if (evento) begin
         unique case (estado_q)
            ESPERA_A, LISTO: begin
               // valido drops together with the new A so no mixed set is flagged
               a_d      = sw_dato;
               valido_d = 1'b0;
               estado_d = ESPERA_B;
            end
            ESPERA_B: begin
               b_d      = sw_dato;
               estado_d = ESPERA_OP;
            end
            ESPERA_OP: begin
               if (op_ok) begin
                  op_d     = sw_op;
                  valido_d = 1'b1;
                  estado_d = LISTO;
               end else begin
`ifdef OP_VALIDACION_EN
                  op_invalida_d = 1'b1;
`endif
               end
            end
            default: estado_d = ESPERA_A;
         endcase
      end
   end

   // State and capture registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         estado_q <= ESPERA_A;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         valido_q <= 1'b0;
      end else begin
         estado_q <= estado_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         valido_q <= valido_d;
      end
   end

`ifdef OP_VALIDACION_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) op_invalida_q <= 1'b0;
      else     op_invalida_q <= op_invalida_d;
   end
   assign op_invalida = op_invalida_q;
`else
   assign op_invalida = 1'b0;
`endif

   assign a         = a_q;
   assign b         = b_q;
   assign operacion = op_q;
   assign valido    = valido_q;
   assign estado    = estado_q;

endmodule : captura_operandos

// File: doc/captura_operandos.md
Name: captura_operandos

Overview:
- Upstream input stage for the calculator datapath.
- Sequences operand A, operand B and the 4-bit operation code from board switches, one item per debounced press of a single "load" button.
- Holds all three in registers and presents them, with a valid flag, to the combinational ALU/mux/decoder stage.
- That downstream stage sees stable operands, never raw switch values.

Parameters:
N, 4, operand width; must match the calculator's n.
DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a button level change (≥1; benches use 4).

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
btn_cargar  input  1  raw load pushbutton (asynchronous, bouncy, active-high)
sw_dato  input  N  operand switches
sw_op  input  4  operation-code switches
a  output  N  registered operand A
b  output  N  registered operand B
operacion  output  4  registered operation code
valido  output  1  high while a/b/operacion form a complete, consistent set
estado  output  2  current FSM state (for LEDs)
op_invalida  output  1  one-cycle pulse on rejected op code (see Optional Feature)

Behaviour:
- Reset (async assert, sampled release): a=0, b=0, operacion=0, valido=0, estado=ESPERA_A(0), op_invalida=0, debounce counter=0, debounced level=0, synchronizer flops=0.
- Input conditioning: btn_cargar passes through a 2-flop synchronizer.
- Debounced level toggles only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears the counter.
- Counter width is $clog2(DEBOUNCE_CYCLES+1).
- A press event (evento) is a one-cycle pulse on the 0->1 transition of the debounced level.
  - Release generates no event.
  - Holding the button generates exactly one event.
  - Pulses shorter than DEBOUNCE_CYCLES are ignored.
- Latency: a clean rising btn_cargar sampled at edge k yields evento high during cycle k+2+DEBOUNCE_CYCLES. The capture register updates at the end of that cycle.
- sw_dato/sw_op are sampled only on the evento cycle; they are not synchronized (operator sets switches before pressing).
- FSM (states encoded 0..3):
  - ESPERA_A: evento -> a<=sw_dato, valido<=0, go ESPERA_B.
  - ESPERA_B: evento -> b<=sw_dato, go ESPERA_OP.
  - ESPERA_OP: evento -> operacion<=sw_op, valido<=1, go LISTO.
  - LISTO: evento -> a<=sw_dato, valido<=0, go ESPERA_B. A new sequence starts immediately; no idle press.
- Without evento, every state holds and all registers keep their values.
- valido drops in the same cycle a is overwritten in LISTO, so a/b/operacion are never flagged valid while mixed.
- Registers not being loaded keep old values: in ESPERA_B, b and operacion still hold the previous set with valido=0.
- Reset mid-sequence or mid-debounce returns to ESPERA_A with all outputs cleared. A button still held after reset release becomes an event only after a full debounce interval.

Optional Feature:
- Macro: OP_VALIDACION_EN.
- Defined: in ESPERA_OP, an evento with sw_op ≥ 10 (outside the 10 implemented operations) does not load operacion and stays in ESPERA_OP. op_invalida pulses high for that one cycle; valido stays 0.
- Undefined: every sw_op value is accepted; op_invalida is tied to 0.

Decomposition:
- Package calc_pkg:
  - enum logic [1:0] estado_t {ESPERA_A=0, ESPERA_B=1, ESPERA_OP=2, LISTO=3}
  - localparam NUM_OPS=10
  - Shared with the calculator mux/decoder.
- Sub-module antirrebote (params DEBOUNCE_CYCLES; ports clk, rst, btn_in, nivel, evento): synchronizer + counter + edge detect. Top level instantiates it once and contains only the FSM and capture registers.

Test Plan (N=4, DEBOUNCE_CYCLES=4):
1. Full sequence: presses with sw_dato=4'h5, then 4'h3, then sw_op=4'h0.
   - a=5, b=3, operacion=0, valido=1, estado=3.
   - Each register updates exactly 7 cycles after its btn rise.
2. Bounce: btn high 3 cycles, low 1, high 2, low.
   - No evento, estado stays 0.
   - Then btn held high 20 cycles: exactly one load.
3. Restart from LISTO: press with sw_dato=4'hA.
   - Same cycle: a=A, valido=0, estado=1.
   - b and operacion keep their previous values.
4. Async reset asserted in ESPERA_OP mid-debounce.
   - Outputs 0 and estado=0 immediately, without waiting for a clock edge.
   - Held button after release is accepted only after 4+2 cycles.
5. With OP_VALIDACION_EN, sw_op=4'hC in ESPERA_OP:
   - op_invalida pulses 1 cycle, estado stays 2, operacion unchanged.
   - Then sw_op=4'h9: loads, valido=1.
6. Without OP_VALIDACION_EN, sw_op=4'hF: accepted, operacion=F, op_invalida stays 0.
